// File: rtl/fp_sum3_operand_gather.sv
// Groups a valid/ready stream of IEEE-754 operands into {a,b,c,rnd} triples for DW_fp_sum3.
// Short packet tails are padded with +0.0. The output group stays stable while it waits for the adder.
module fp_sum3_operand_gather #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [sig_width+exp_width:0]   i_in_data,
  input  logic [2:0]                     i_in_rnd,
  input  logic                           i_in_last,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  output logic [sig_width+exp_width:0]   o_grp_a,
  output logic [sig_width+exp_width:0]   o_grp_b,
  output logic [sig_width+exp_width:0]   o_grp_c,
  output logic [2:0]                     o_grp_rnd,
  output logic [1:0]                     o_grp_nops,
  output logic                           o_grp_last,
  output logic                           o_grp_valid,
  input  logic                           i_grp_ready,
  output logic [1:0]                     o_dbg_cnt
);
  localparam int W = sig_width + exp_width + 1;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // valid never depends on ready. Once raised, valid and its payload hold until the beat transfers.
  logic [1:0]   r_cnt;
  logic [W-1:0] r_s0;
  logic [W-1:0] r_s1;
  logic [2:0]   r_rnd_s;
  logic [W-1:0] r_grp_a;
  logic [W-1:0] r_grp_b;
  logic [W-1:0] r_grp_c;
  logic [2:0]   r_grp_rnd;
  logic [1:0]   r_grp_nops;
  logic         r_grp_last;
  logic         r_grp_valid;

  logic w_closing;
  logic w_accept;
  logic w_complete;

  // A closing operand needs the output register free (or draining this cycle).
  // Any other operand only needs a free gather slot, which always exists.
  assign w_closing  = (r_cnt == 2'd2) | i_in_last;
  assign o_in_ready = ~w_closing | ~r_grp_valid | i_grp_ready;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_complete = w_accept & w_closing;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 2'd0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_rnd_s     <= 3'd0;
      r_grp_a     <= '0;
      r_grp_b     <= '0;
      r_grp_c     <= '0;
      r_grp_rnd   <= 3'd0;
      r_grp_nops  <= 2'd0;
      r_grp_last  <= 1'b0;
      r_grp_valid <= 1'b0;
    end else if (w_complete) begin
      r_cnt       <= 2'd0;
      r_grp_valid <= 1'b1;
      r_grp_last  <= i_in_last;
      r_grp_rnd   <= (r_cnt == 2'd0) ? i_in_rnd : r_rnd_s;
      case (r_cnt)
        2'd0: begin
          r_grp_a    <= i_in_data;
          r_grp_b    <= '0;
          r_grp_c    <= '0;
          r_grp_nops <= 2'd1;
        end
        2'd1: begin
          r_grp_a    <= r_s0;
          r_grp_b    <= i_in_data;
          r_grp_c    <= '0;
          r_grp_nops <= 2'd2;
        end
        default: begin
          r_grp_a    <= r_s0;
          r_grp_b    <= r_s1;
          r_grp_c    <= i_in_data;
          r_grp_nops <= 2'd3;
        end
      endcase
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd0) begin
          r_s0    <= i_in_data;
          r_rnd_s <= i_in_rnd;
        end else begin
          r_s1 <= i_in_data;
        end
      end
      if (i_grp_ready) r_grp_valid <= 1'b0;
    end
  end

  assign o_grp_a     = r_grp_a;
  assign o_grp_b     = r_grp_b;
  assign o_grp_c     = r_grp_c;
  assign o_grp_rnd   = r_grp_rnd;
  assign o_grp_nops  = r_grp_nops;
  assign o_grp_last  = r_grp_last;
  assign o_grp_valid = r_grp_valid;
  assign o_dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_fp_sum3_operand_gather.sv
// Bench for fp_sum3_operand_gather: directed scenarios plus randomized traffic, checked by a
// packet-level operand model feeding an expected-group queue that a monitor drains.
module tb_fp_sum3_operand_gather;
  localparam int W  = 32;
  localparam int GW = 3 * W + 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [2:0]   in_rnd;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] grp_a;
  logic [W-1:0] grp_b;
  logic [W-1:0] grp_c;
  logic [2:0]   grp_rnd;
  logic [1:0]   grp_nops;
  logic         grp_last;
  logic         grp_valid;
  logic         grp_ready;
  logic [1:0]   dbg_cnt;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test sequence
  logic [GW-1:0] exp_q[$];

  fp_sum3_operand_gather dut (
    .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_rnd(in_rnd), .i_in_last(in_last),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_grp_a(grp_a), .o_grp_b(grp_b),
    .o_grp_c(grp_c), .o_grp_rnd(grp_rnd), .o_grp_nops(grp_nops), .o_grp_last(grp_last),
    .o_grp_valid(grp_valid), .i_grp_ready(grp_ready), .o_dbg_cnt(dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) grp_ready = 1'b1;
    else if (ready_mode == 1) grp_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [GW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [2:0] r,
                                         input logic [1:0] n, input logic l);
    return {a, b, c, r, n, l};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model: operand list per packet ----------------
  logic [W-1:0] pend_d[3];
  logic [2:0]   pend_r[3];
  int           pend_n = 0;
  logic         m_valid = 1'b0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic complete;
    if (rst) begin
      pend_n  = 0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      check("grp_valid", grp_valid, m_valid);
      exp_rdy = !((pend_n == 2) || in_last) || !m_valid || grp_ready;
      if (in_valid) check("in_ready", in_ready, exp_rdy);
      complete = 1'b0;
      if (in_valid && exp_rdy) begin
        pend_d[pend_n] = in_data;
        pend_r[pend_n] = in_rnd;
        pend_n++;
        if (pend_n == 3 || in_last) begin
          exp_q.push_back(pack(pend_d[0], (pend_n > 1) ? pend_d[1] : '0,
                               (pend_n > 2) ? pend_d[2] : '0, pend_r[0], 2'(pend_n), in_last));
          pend_n   = 0;
          complete = 1'b1;
        end
      end
      m_valid = complete | (m_valid & ~grp_ready);
    end
  end

  // ---------------- monitor: pops expected groups, checks hold stability ----------------
  logic          held = 1'b0;
  logic [GW-1:0] held_val;

  always @(negedge clk) begin
    logic [GW-1:0] cur;
    cur = pack(grp_a, grp_b, grp_c, grp_rnd, grp_nops, grp_last);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && grp_valid) check("grp_stable", cur, held_val);
      if (grp_valid && grp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_group", 1, 0);
        end else begin
          check("group", cur, exp_q.pop_front());
        end
      end
      held     = grp_valid & ~grp_ready;
      held_val = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_op(input logic [W-1:0] d, input logic [2:0] r, input logic l,
                          output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_rnd   = r;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) check("accept_timeout", stalls, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int tot;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rnd = '0; in_last = 1'b0; grp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset mid-group with a held output group
    ready_mode = 2;
    grp_ready  = 1'b0;
    drive_op(32'h11111111, 3'd1, 1'b0, st);
    drive_op(32'h22222222, 3'd2, 1'b0, st);
    drive_op(32'h33333333, 3'd3, 1'b0, st);
    drive_op(32'h44444444, 3'd4, 1'b0, st);
    drive_op(32'h55555555, 3'd5, 1'b0, st);
    check("t1_cnt_before_reset", dbg_cnt, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_grp_valid", grp_valid, 0);
    check("t1_grp_zero", pack(grp_a, grp_b, grp_c, grp_rnd, grp_nops, grp_last), 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_cnt", dbg_cnt, 0);
    @(posedge clk);
    #1;
    ready_mode = 0;
    drive_op(32'h3F800000, 3'd0, 1'b0, st);
    drive_op(32'h40000000, 3'd0, 1'b0, st);
    drive_op(32'h40400000, 3'd0, 1'b0, st);
    wait_drain();

    // 2: two full groups streamed back to back
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      d = 32'h3F800000;
      case (i)
        1: d = 32'h40000000;
        2: d = 32'h40400000;
        3: d = 32'h40800000;
        4: d = 32'h40A00000;
        5: d = 32'h40C00000;
        default: ;
      endcase
      drive_op(d, 3'd0, 1'b0, st);
      tot += st;
    end
    check("t2_stalls", tot, 0);
    wait_drain();

    // 3: short packet tails padded with +0.0
    drive_op(32'h3F800000, 3'd0, 1'b0, st);
    drive_op(32'h40000000, 3'd0, 1'b1, st);
    drive_op(32'h40400000, 3'd0, 1'b1, st);
    wait_drain();

    // 4: output held, gather keeps filling, closing operand waits for grp_ready
    ready_mode = 2;
    grp_ready  = 1'b0;
    drive_op(32'h7FC00000, 3'd2, 1'b0, st);
    drive_op(32'h7F800000, 3'd2, 1'b0, st);
    drive_op(32'h00000001, 3'd2, 1'b0, st);
    drive_op(32'hFF800000, 3'd1, 1'b0, st);
    drive_op(32'h80000000, 3'd1, 1'b0, st);
    in_valid = 1'b1; in_data = 32'hC1200000; in_rnd = 3'd3; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    grp_ready = 1'b1;
    @(negedge clk);
    check("t4_in_ready_high", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("t4_new_group_valid", grp_valid, 1);
    wait_drain();

    // 5: continuous completes with downstream always ready
    tot = 0;
    for (int i = 0; i < 9; i++) begin
      drive_op($urandom, 3'($urandom_range(0, 7)), 1'b0, st);
      tot += st;
    end
    check("t5_stalls", tot, 0);
    wait_drain();

    // 6: rounding mode taken from the first operand of each group
    drive_op(32'h3F800000, 3'b001, 1'b0, st);
    drive_op(32'h40000000, 3'b011, 1'b0, st);
    drive_op(32'h40400000, 3'b011, 1'b0, st);
    drive_op(32'h40800000, 3'b100, 1'b1, st);
    wait_drain();

    // randomized traffic with random backpressure and packet lengths
    ready_mode = 1;
    for (int i = 0; i < 240; i++) begin
      #(10 * $urandom_range(0, 2));
      drive_op($urandom, 3'($urandom_range(0, 7)), (i == 239) || ($urandom_range(0, 3) == 0), st);
    end
    ready_mode = 0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
